// File: rtl/alu_shift_seq.sv
// Shift/rotate sequencer driving an external ALU through SH (shift/load) and RES (result) phases.
// Build option ALU_SHIFT_SEQ_SWAP_EN: SWAP runs as four RLC passes; otherwise SWAP returns an error response.
module alu_shift_seq (
  input  logic       clk,
  input  logic       nreset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [2:0] req_op,
  input  logic [7:0] req_data,
  input  logic       req_cin,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_z,
  output logic       rsp_c,
  output logic       rsp_err,
  output logic       alu_en,
  output logic [7:0] alu_op,
  output logic       alu_si,
  output logic       alu_sh,
  output logic       alu_ld,
  output logic       alu_res_oe,
  output logic       alu_l,
  output logic       alu_h,
  input  logic       alu_shift_dbl,
  input  logic [7:0] alu_result,
  input  logic       alu_zero
);

  typedef enum logic [1:0] {IDLE, SH, RES} state_t;
  typedef enum logic [2:0] {
    OP_RLC, OP_RRC, OP_RL, OP_RR, OP_SLA, OP_SRA, OP_SWAP, OP_SRL
  } op_t;

  state_t     state;
  logic [2:0] op_q;
  logic       carry_q;
`ifdef ALU_SHIFT_SEQ_SWAP_EN
  logic [1:0] pass_q;
`endif

  // Bit entering the vacated end of the operand for each operation.
  function automatic logic shift_in(input logic [2:0] op, input logic [7:0] d, input logic cin);
    case (op_t'(op))
      OP_RLC, OP_SRA, OP_SWAP: shift_in = d[7];
      OP_RRC:                  shift_in = d[0];
      OP_RL, OP_RR:            shift_in = cin;
      default:                 shift_in = 1'b0;
    endcase
  endfunction

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= IDLE;
      op_q       <= 3'd0;
      carry_q    <= 1'b0;
`ifdef ALU_SHIFT_SEQ_SWAP_EN
      pass_q     <= 2'd0;
`endif
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_data   <= 8'h00;
      rsp_z      <= 1'b0;
      rsp_c      <= 1'b0;
      rsp_err    <= 1'b0;
      alu_en     <= 1'b0;
      alu_op     <= 8'h00;
      alu_si     <= 1'b0;
      alu_sh     <= 1'b0;
      alu_ld     <= 1'b0;
      alu_res_oe <= 1'b0;
      alu_l      <= 1'b0;
      alu_h      <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q <= req_op;
`ifdef ALU_SHIFT_SEQ_SWAP_EN
            pass_q <= 2'd0;
`else
            if (req_op == OP_SWAP) begin
              // Unsupported in this build: answer immediately without touching the ALU.
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= req_data;
              rsp_z     <= 1'b0;
              rsp_c     <= 1'b0;
            end else
`endif
            begin
              state      <= SH;
              req_ready  <= 1'b0;
              alu_en     <= 1'b1;
              alu_op     <= req_data;
              alu_si     <= shift_in(req_op, req_data, req_cin);
              alu_sh     <= req_op[0];  // odd opcodes shift right
              alu_ld     <= 1'b1;
              alu_res_oe <= 1'b0;
              alu_l      <= 1'b1;
              alu_h      <= 1'b0;
            end
          end
        end

        SH: begin
          carry_q    <= alu_shift_dbl;
          state      <= RES;
          alu_ld     <= 1'b0;
          alu_res_oe <= 1'b1;
          alu_l      <= 1'b0;
          alu_h      <= 1'b1;
        end

        RES: begin
`ifdef ALU_SHIFT_SEQ_SWAP_EN
          if (op_q == OP_SWAP && pass_q != 2'd3) begin
            // Another RLC pass on the result just produced.
            pass_q     <= pass_q + 2'd1;
            state      <= SH;
            alu_op     <= alu_result;
            alu_si     <= alu_result[7];
            alu_ld     <= 1'b1;
            alu_res_oe <= 1'b0;
            alu_l      <= 1'b1;
            alu_h      <= 1'b0;
          end else
`endif
          begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b1;
            rsp_data   <= alu_result;
            rsp_z      <= alu_zero;
            rsp_c      <= (op_q == OP_SWAP) ? 1'b0 : carry_q;
            rsp_err    <= 1'b0;
            alu_en     <= 1'b0;
            alu_op     <= 8'h00;
            alu_si     <= 1'b0;
            alu_sh     <= 1'b0;
            alu_ld     <= 1'b0;
            alu_res_oe <= 1'b0;
            alu_l      <= 1'b0;
            alu_h      <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_shift_seq.sv
// Directed bench for alu_shift_seq with a small behavioural model of the external ALU.
// Expectations follow the ALU_SHIFT_SEQ_SWAP_EN build setting.
module tb_alu_shift_seq;

  logic       clk = 1'b0;
  logic       nreset;
  logic       req_valid, req_ready, req_cin;
  logic [2:0] req_op;
  logic [7:0] req_data;
  logic       rsp_valid, rsp_z, rsp_c, rsp_err;
  logic [7:0] rsp_data;
  logic       alu_en, alu_si, alu_sh, alu_ld, alu_res_oe, alu_l, alu_h;
  logic [7:0] alu_op;
  logic       alu_shift_dbl, alu_zero;
  logic [7:0] alu_result;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_shift_seq dut (
    .clk(clk), .nreset(nreset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_data(req_data), .req_cin(req_cin),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_z(rsp_z),
    .rsp_c(rsp_c), .rsp_err(rsp_err),
    .alu_en(alu_en), .alu_op(alu_op), .alu_si(alu_si), .alu_sh(alu_sh),
    .alu_ld(alu_ld), .alu_res_oe(alu_res_oe), .alu_l(alu_l), .alu_h(alu_h),
    .alu_shift_dbl(alu_shift_dbl), .alu_result(alu_result), .alu_zero(alu_zero)
  );

  // External ALU: the shifter exposes the outgoing bit, the latch holds the shifted value.
  logic [7:0] alu_a = 8'h00;
  assign alu_shift_dbl = alu_sh ? alu_op[0] : alu_op[7];
  assign alu_result    = alu_a;
  assign alu_zero      = (alu_a == 8'h00);
  always @(posedge clk)
    if (alu_ld) alu_a <= alu_sh ? {alu_si, alu_op[7:1]} : {alu_op[6:0], alu_si};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, wait (bounded) for its response and check it.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [7:0] data,
                       input logic cin, input logic [7:0] e_data, input logic e_z,
                       input logic e_c, input logic e_err, input int e_lat, input int e_ld);
    int lat;
    int ld_cnt;
    req_valid = 1'b1; req_op = op; req_data = data; req_cin = cin;
    tick();
    req_valid = 1'b0; req_data = ~data; req_cin = ~cin; req_op = 3'd0;
    lat = 0; ld_cnt = 0;
    while (!rsp_valid && lat < 20) begin
      ld_cnt += int'(alu_ld);
      tick();
      lat++;
    end
    check({tag, "_lat"},  lat, e_lat);
    check({tag, "_ld"},   ld_cnt, e_ld);
    check({tag, "_rv"},   rsp_valid, 1'b1);
    check({tag, "_data"}, rsp_data, e_data);
    check({tag, "_z"},    rsp_z, e_z);
    check({tag, "_c"},    rsp_c, e_c);
    check({tag, "_err"},  rsp_err, e_err);
    check({tag, "_rdy"},  req_ready, 1'b1);
    tick();
  endtask

  initial begin
    int seen;
    nreset = 1'b0; req_valid = 1'b0; req_op = 3'd0; req_data = 8'h00; req_cin = 1'b0;
    tick(); tick();
    check("rst_ready", req_ready, 1'b1);
    check("rst_rv",    rsp_valid, 1'b0);
    check("rst_rsp",   {rsp_data, rsp_z, rsp_c, rsp_err}, 11'h0);
    check("rst_alu",   {alu_en, alu_op, alu_si, alu_sh, alu_ld, alu_res_oe, alu_l, alu_h}, 15'h0);
    nreset = 1'b1;
    tick();

    // SRL 0x81 cycle by cycle
    req_valid = 1'b1; req_op = 3'd7; req_data = 8'h81;
    tick();
    req_valid = 1'b0; req_data = 8'hFF;
    check("srl_sh_ctl", {alu_en, alu_ld, alu_res_oe, alu_l, alu_h, req_ready}, 6'b110100);
    check("srl_sh_dir", {alu_sh, alu_si}, 2'b10);
    check("srl_sh_op",  alu_op, 8'h81);
    tick();
    check("srl_res_ctl", {alu_en, alu_ld, alu_res_oe, alu_l, alu_h, rsp_valid}, 6'b101010);
    tick();
    check("srl_rsp", {rsp_valid, rsp_data, rsp_z, rsp_c, rsp_err}, {1'b1, 8'h40, 3'b010});
    check("srl_idle", {req_ready, alu_en}, 2'b10);
    tick();
    check("srl_hold", {rsp_valid, rsp_data, rsp_c}, {1'b0, 8'h40, 1'b1});

    do_op("srl01", 3'd7, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2, 1);
    req_valid = 1'b1; req_op = 3'd2; req_data = 8'h80; req_cin = 1'b1;
    tick();
    req_valid = 1'b0;
    check("rl_si", {alu_sh, alu_si}, 2'b01);
    tick(); tick();
    check("rl_rsp", {rsp_valid, rsp_data, rsp_z, rsp_c}, {1'b1, 8'h01, 2'b01});
    tick();
    do_op("sra", 3'd5, 8'h81, 1'b0, 8'hC0, 1'b0, 1'b1, 1'b0, 2, 1);
    do_op("rlc", 3'd0, 8'hA5, 1'b0, 8'h4B, 1'b0, 1'b1, 1'b0, 2, 1);
    do_op("rr",  3'd3, 8'h02, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0, 2, 1);

`ifdef ALU_SHIFT_SEQ_SWAP_EN
    do_op("swap", 3'd6, 8'h3C, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, 8, 4);
`else
    do_op("swap", 3'd6, 8'h3C, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 0, 0);
    check("swap_no_alu", alu_en, 1'b0);
`endif

    // Back-to-back with req_valid held; busy-time request changes are ignored
    req_valid = 1'b1; req_op = 3'd4; req_data = 8'h40; req_cin = 1'b0;
    tick();
    req_op = 3'd1; req_data = 8'h01;
    tick(); tick();
    check("b2b_rsp1", {rsp_valid, rsp_data, rsp_c, req_ready}, {1'b1, 8'h80, 2'b01});
    tick();
    req_valid = 1'b0;
    check("b2b_sh2", {alu_en, alu_op, alu_sh, alu_si}, {1'b1, 8'h01, 2'b11});
    tick(); tick();
    check("b2b_rsp2", {rsp_valid, rsp_data, rsp_c, rsp_z}, {1'b1, 8'h80, 2'b10});
    tick();

    // Reset asserted during RES of SRL 0xFF
    req_valid = 1'b1; req_op = 3'd7; req_data = 8'hFF;
    tick();
    req_valid = 1'b0;
    tick();
    check("abort_in_res", alu_res_oe, 1'b1);
    #2 nreset = 1'b0;
    #1;
    check("abort_async", {alu_en, alu_res_oe, alu_h, req_ready, rsp_valid, rsp_data}, {5'b00010, 8'h00});
    tick();
    nreset = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      seen += int'(rsp_valid);
      tick();
    end
    check("abort_no_rsp", seen, 0);
    check("abort_ready", {req_ready, alu_en}, 2'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_shift_seq.md
ALU_SHIFT_SEQ -- requirements
Module: alu_shift_seq

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  single system clock; all state on rising edge.
REQ-003 nreset  in  1  asynchronous, active-low reset.
REQ-004 req_valid  in  1  shift request present.
REQ-005 req_ready  out  1  sequencer idle; request accepted on clk edge with req_valid&req_ready.
REQ-006 req_op  in  3  0 RLC, 1 RRC, 2 RL, 3 RR, 4 SLA, 5 SRA, 6 SWAP, 7 SRL.
REQ-007 req_data  in  8  operand; req_cin  in  1  carry flag for RL/RR.
REQ-008 rsp_valid  out  1  one-cycle result strobe; rsp_data  out  8; rsp_z, rsp_c, rsp_err  out  1 each.
REQ-009 alu_en  out  1  sequencer owns ALU control lines this cycle.
REQ-010 alu_op  out  8  operand to ALU bus; alu_si  out  1  shift-in bit; alu_sh  out  1  0 left, 1 right.
REQ-011 alu_ld  out  1  load ALU A/B latches from bus; alu_res_oe  out  1  0 shifter drives bus, 1 result drives bus; alu_l, alu_h  out  1 each  low/high phase strobes.
REQ-012 alu_shift_dbl  in  1  bit shifted out; alu_result  in  8; alu_zero  in  1.

Function
REQ-013 States IDLE, SH, RES; SH and RES one cycle each.
REQ-014 IDLE: req_ready=1, alu_en=0, all alu_* outputs 0.
REQ-015 Acceptance in IDLE latches op, data, cin, clears pass counter, next state SH.
REQ-016 SH: alu_en=1, alu_op=latched operand, alu_ld=1, alu_res_oe=0, alu_l=1, alu_h=0, alu_sh per op (left: RLC,RL,SLA,SWAP; right: others), next RES.
REQ-017 alu_si: RLC op[7]; RRC op[0]; RL/RR cin; SLA/SRL 0; SRA op[7]; SWAP op[7].
REQ-018 SH: alu_shift_dbl captured into carry register.
REQ-019 RES: alu_en=1, alu_ld=0, alu_res_oe=1, alu_l=0, alu_h=1; alu_result and alu_zero captured.
REQ-020 RES with no further pass: next IDLE, rsp_valid=1 for exactly the first IDLE cycle, rsp_data=captured result, rsp_z=captured zero, rsp_c=captured carry (0 for SWAP), rsp_err=0.
REQ-021 Latency: acceptance edge E0 -> SH cycle -> RES cycle -> rsp_valid cycle after third edge; req_ready high in rsp_valid cycle, throughput one op per 3 cycles.
REQ-022 req_valid while not in IDLE ignored; req_* changes after acceptance have no effect.
REQ-023 rsp_* outputs hold last values when rsp_valid=0; only rsp_valid qualifies them.

Reset
REQ-024 nreset low: state IDLE, pass counter 0, req_ready=1, rsp_valid=0, rsp_data=0, rsp_z/rsp_c/rsp_err=0, alu_en and all alu_* outputs 0, asynchronously.
REQ-025 Reset during SH or RES aborts op; no rsp_valid generated for it.

Configuration
REQ-026 Macro ALU_SHIFT_SEQ_SWAP_EN.
REQ-027 Defined: SWAP runs four SH/RES passes of RLC-style rotate, each pass operand = previous captured result; 2-bit pass counter; rsp_valid after 8th ALU cycle; rsp_c=0, rsp_z from last pass.
REQ-028 Undefined: SWAP accepted, no ALU cycles, next cycle rsp_valid=1, rsp_err=1, rsp_data=req_data, rsp_z=0, rsp_c=0.

Verification
REQ-029 SRL 0x81 -> SH cycle alu_sh=1, alu_si=0; rsp_data=0x40, rsp_c=1, rsp_z=0, rsp_valid 3 cycles after acceptance.
REQ-030 SRL 0x01 -> rsp_data=0x00, rsp_z=1, rsp_c=1.
REQ-031 RL 0x80 cin=1 -> alu_si=1; rsp_data=0x01, rsp_c=1; SRA 0x81 -> rsp_data=0xC0, rsp_c=1.
REQ-032 SWAP 0x3C: with macro rsp_data=0xC3, rsp_c=0, 4 SH/RES pairs; without macro rsp_err=1 one cycle after acceptance, alu_en never 1.
REQ-033 Back-to-back: req_valid held with SLA 0x40 then RRC 0x01 -> rsp 0x80 c=0 then 0x80 c=1, second accepted in first rsp_valid cycle.
REQ-034 nreset low during RES of SRL 0xFF -> alu_en=0, rsp_valid never asserted, req_ready=1 after release.
